// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler for the 4-way alpha/beta/gamma/combine mux.
// It grants one requester per item, captures the mux result and holds it on a valid/ready port.
module mux_rr_scheduler #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [3:0]   req,
  output logic [3:0]   ack,
  output logic [1:0]   mux_sel,
  output logic         mux_cs,
  input  logic [W-1:0] mux_out,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int CNT_W = (BURST < 1) ? 1 : $clog2(BURST + 1);
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [1:0]       sel_nxt;
  logic [1:0]       last;
  logic [CNT_W-1:0] burst_cnt;
  logic [3:0]       others;

  // First set bit scanning from+1, from+2, from+3, then from itself.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] from);
    logic [1:0] pick;
    pick = from;
    for (int k = 4; k >= 1; k--) begin
      if (r[from + 2'(k)]) pick = from + 2'(k);
    end
    return pick;
  endfunction

  // A repeat grant extends the burst; a full burst or a new winner restarts it at 1.
  function automatic logic [CNT_W-1:0] burst_next(input logic [CNT_W-1:0] cnt, input logic same);
    if (same && (cnt < BURST_C)) return cnt + CNT_W'(1);
    return CNT_W'(1);
  endfunction

  assign others = req & ~(4'b0001 << last);

  always_comb begin
    state_nxt = state;
    sel_nxt   = mux_sel;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt   = rr_pick(req, last);
          state_nxt = GRANT;
        end
      end
      GRANT: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (req[last] && (burst_cnt < BURST_C)) begin
            sel_nxt   = last;
            state_nxt = GRANT;
          end else if (|others) begin
            sel_nxt   = rr_pick(others, last);
            state_nxt = GRANT;
          end else if (req[last]) begin
            sel_nxt   = last;
            state_nxt = GRANT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      mux_sel   <= 2'd0;
      last      <= 2'd3;
      burst_cnt <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      mux_sel <= sel_nxt;
      // capture stage: mux result lands in out_data the cycle after GRANT
      if (state == GRANT) begin
        out_data  <= mux_out;
        out_valid <= 1'b1;
        burst_cnt <= burst_next(burst_cnt, mux_sel == last);
        last      <= mux_sel;
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign mux_cs = (state == GRANT);
  assign ack    = mux_cs ? (4'b0001 << mux_sel) : 4'b0000;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed bench for mux_rr_scheduler with a behavioural alpha/beta/gamma/combine mux.
module tb_mux_rr_scheduler;

  localparam logic [7:0] ALPHA = 8'h0A;
  localparam logic [7:0] BETA  = 8'h14;
  localparam logic [7:0] GAMMA = 8'h1E;

  logic       clk = 1'b0;
  logic       nreset;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] mux_sel;
  logic       mux_cs;
  logic [7:0] mux_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mux_rr_scheduler #(.W(8), .BURST(4)) dut (
    .clk(clk), .nreset(nreset), .req(req), .ack(ack),
    .mux_sel(mux_sel), .mux_cs(mux_cs), .mux_out(mux_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    mux_out = 8'h00;
    if (mux_cs) begin
      case (mux_sel)
        2'd0:    mux_out = ALPHA;
        2'd1:    mux_out = BETA;
        2'd2:    mux_out = GAMMA;
        default: mux_out = ALPHA & (BETA | GAMMA);
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req       = 4'b0000;
    out_ready = 1'b1;
    nreset    = 1'b0;
    step();
    step();
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b0000; out_ready = 1'b1; nreset = 1'b0;
    step(); step();
    total_cnt++;
    if ({busy, out_valid, out_data, mux_cs, mux_sel, ack} !== {1'b0, 1'b0, 8'h00, 1'b0, 2'd0, 4'b0000})
      $display("FAIL rst_state got %h exp %h", {busy, out_valid, out_data, mux_cs, mux_sel, ack}, 17'h0);
    else pass_cnt++;
    nreset = 1'b1;
    req = 4'b1111;
    step();
    total_cnt++;
    if ({mux_cs, mux_sel, ack} !== {1'b1, 2'd0, 4'b0001})
      $display("FAIL rst_first_grant got %h exp %h", {mux_cs, mux_sel, ack}, {1'b1, 2'd0, 4'b0001});
    else pass_cnt++;
    req = 4'b0000; out_ready = 1'b0;
    step();
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, ALPHA})
      $display("FAIL rst_hold_data got %h exp %h", {out_valid, out_data}, {1'b1, ALPHA});
    else pass_cnt++;
    #2 nreset = 1'b0;
    #1;
    total_cnt++;
    if ({out_valid, out_data, mux_cs, ack, busy} !== {1'b0, 8'h00, 1'b0, 4'b0000, 1'b0})
      $display("FAIL rst_mid_hold got %h exp %h", {out_valid, out_data, mux_cs, ack, busy}, 15'h0);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    nreset = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0010;
    step();
    total_cnt++;
    if ({mux_cs, mux_sel, ack} !== {1'b1, 2'd1, 4'b0010})
      $display("FAIL single_grant got %h exp %h", {mux_cs, mux_sel, ack}, {1'b1, 2'd1, 4'b0010});
    else pass_cnt++;
    req = 4'b0000;
    step();
    total_cnt++;
    if ({out_valid, out_data, mux_cs, ack} !== {1'b1, BETA, 1'b0, 4'b0000})
      $display("FAIL single_data got %h exp %h", {out_valid, out_data, mux_cs, ack}, {1'b1, BETA, 1'b0, 4'b0000});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({busy, out_valid} !== 2'b00)
      $display("FAIL single_idle got %b exp %b", {busy, out_valid}, 2'b00);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_data [4];
    logic [3:0] exp_ack;
    exp_data[0] = ALPHA; exp_data[1] = BETA; exp_data[2] = GAMMA; exp_data[3] = 8'h0A;
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      exp_ack = 4'b0001 << k;
      total_cnt++;
      if ({mux_cs, mux_sel, ack} !== {1'b1, 2'(k), exp_ack})
        $display("FAIL rr_grant%0d got %h exp %h", k, {mux_cs, mux_sel, ack}, {1'b1, 2'(k), exp_ack});
      else pass_cnt++;
      req[k] = 1'b0;
      step();
      total_cnt++;
      if ({out_valid, out_data, ack} !== {1'b1, exp_data[k], 4'b0000})
        $display("FAIL rr_data%0d got %h exp %h", k, {out_valid, out_data, ack}, {1'b1, exp_data[k], 4'b0000});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rr_idle got %b exp %b", busy, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    req = 4'b0001;
    step();
    req = 4'b0100; out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({out_valid, out_data, ack, mux_cs} !== {1'b1, ALPHA, 4'b0000, 1'b0})
        $display("FAIL bp_hold%0d got %h exp %h", i, {out_valid, out_data, ack, mux_cs}, {1'b1, ALPHA, 4'b0000, 1'b0});
      else pass_cnt++;
      step();
    end
    out_ready = 1'b1;
    step();
    total_cnt++;
    if ({mux_cs, mux_sel, ack} !== {1'b1, 2'd2, 4'b0100})
      $display("FAIL bp_release got %h exp %h", {mux_cs, mux_sel, ack}, {1'b1, 2'd2, 4'b0100});
    else pass_cnt++;
    req = 4'b0000;
    step();
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, GAMMA})
      $display("FAIL bp_data got %h exp %h", {out_valid, out_data}, {1'b1, GAMMA});
    else pass_cnt++;
    step();
  endtask

  task automatic test_burst();
    logic [3:0] exp_ack;
    req = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      step();
      exp_ack = (k < 4) ? 4'b0001 : 4'b0010;
      total_cnt++;
      if (ack !== exp_ack) $display("FAIL burst_grant%0d got %b exp %b", k, ack, exp_ack);
      else pass_cnt++;
      if (k == 4) req = 4'b0000;
      step();
    end
    step();
    req = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      total_cnt++;
      if ({mux_cs, ack} !== {1'b1, 4'b0001})
        $display("FAIL solo_grant%0d got %h exp %h", k, {mux_cs, ack}, {1'b1, 4'b0001});
      else pass_cnt++;
      if (k == 5) req = 4'b0000;
      step();
      total_cnt++;
      if ({out_valid, out_data, ack} !== {1'b1, ALPHA, 4'b0000})
        $display("FAIL solo_hold%0d got %h exp %h", k, {out_valid, out_data, ack}, {1'b1, ALPHA, 4'b0000});
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL solo_idle got %b exp %b", busy, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_wrap_withdraw();
    req = 4'b1000;
    step();
    total_cnt++;
    if (ack !== 4'b1000) $display("FAIL wrap_pre got %b exp %b", ack, 4'b1000);
    else pass_cnt++;
    req = 4'b0000;
    step(); step();
    req = 4'b1001;
    step();
    total_cnt++;
    if ({mux_sel, ack} !== {2'd0, 4'b0001})
      $display("FAIL wrap_grant got %h exp %h", {mux_sel, ack}, {2'd0, 4'b0001});
    else pass_cnt++;
    req = 4'b0000;
    step(); step();
    req = 4'b0100;
    #2 req = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if ({busy, mux_cs, ack} !== {1'b0, 1'b0, 4'b0000})
        $display("FAIL withdraw%0d got %h exp %h", i, {busy, mux_cs, ack}, 6'h0);
      else pass_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; req = 4'b0000; out_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_burst();
    test_wrap_withdraw();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
